rx_eth: RTL and testbench
=========================

# rx_eth

Receive-side counterpart of the MII transmit chain. The block consumes 4-bit MII receive nibbles and strips preamble/SFD. It parses the 14-byte Ethernet header, filters on destination MAC and removes the 4-byte FCS. Payload is delivered as a byte-wide AXI-stream to downstream IP/UDP receive parsers, with a per-frame error flag on the last beat.

## Interface
- Parameters:
  - MIN_FRAME, 64: minimum legal frame length in bytes, dst MAC through FCS inclusive.
- Ports:
  - clk  in  1  MII receive data clock; the only clock.
  - rst_n  in  1  asynchronous active-low reset.
  - rxd  in  4  MII receive nibble, low nibble of each byte first.
  - rx_dv  in  1  receive data valid.
  - rx_er  in  1  receive error from PHY.
  - local_mac  in  48  station MAC for filtering; quasi-static.
  - dst_mac  out  48  latched destination MAC of current frame.
  - src_mac  out  48  latched source MAC.
  - eth_type  out  16  latched EtherType, network order (first byte = [15:8]).
  - hdr_valid  out  1  one-cycle pulse when the header of an accepted frame is latched.
  - m_axis_tdata  out  8  payload byte.
  - m_axis_tvalid  out  1  one-cycle beat strobe; no tready, the sink must always accept.
  - m_axis_tlast  out  1  last payload byte.
  - m_axis_tuser  out  1  frame error; meaningful only with tlast.
  - rx_err  out  1  one-cycle pulse for a frame aborted with no tlast delivered.

## Operation
- Nibble assembler:
  - Toggles phase each cycle while rx_dv=1. The low nibble is captured first; the byte completes on the high nibble.
  - Phase clears when rx_dv=0.
- State machine:
  - IDLE: when rx_dv rises, go to PREAMBLE.
  - PREAMBLE: nibbles of 0x5 are ignored. Nibble 0xD following a 0x5 is the SFD; go to HEADER with phase aligned so the next nibble is a low nibble. Any other nibble goes to DROP.
  - HEADER: bytes 0-5 load dst_mac, 6-11 load src_mac, 12-13 load eth_type, all MSB-first. After byte 13:
    - Accept if dst_mac equals local_mac or 48'hFFFF_FFFF_FFFF; pulse hdr_valid and go to PAYLOAD.
    - Otherwise go to DROP.
  - PAYLOAD:
    - Post-header bytes enter a 5-byte delay line; each arrival beyond the 5th emits the oldest byte with tvalid=1, tlast=0.
    - On rx_dv falling with n post-header bytes received and n≥5: emit the oldest buffered byte with tlast=1 and discard the remaining 4 (FCS). Then go to IDLE.
    - If n≤4: emit nothing, pulse rx_err, go to IDLE.
  - DROP: wait for rx_dv=0, then go to IDLE. No output and no rx_err (filtered frames are not errors).
- rx_dv falling in PREAMBLE or HEADER: go to IDLE and pulse rx_err, except that a frame with no SFD seen produces no rx_err pulse.
- tuser=1 on the tlast beat if any of the following hold:
  - rx_er was seen at any point in the frame;
  - rx_dv fell on an odd nibble (dribble);
  - total bytes received < MIN_FRAME;
  - CRC failed (see Configuration).
- Byte counter: 11 bits, saturating at 2047. Saturation does not itself raise an error.
- dst_mac, src_mac and eth_type hold their values until the next accepted header.

## Timing
- Reset values:
  - dst_mac, src_mac and eth_type are 0;
  - every 1-bit output is 0;
  - m_axis_tdata is 0;
  - state is IDLE.
- Reset asserted mid-frame: the frame is discarded. After release the block waits in IDLE for the next rx_dv rising edge. A frame already in progress at release is ignored until rx_dv=0 is seen.
- A byte completes on the cycle the high nibble is sampled. Outputs are registered one cycle later, so tvalid for payload byte k appears 1 cycle after the high nibble of post-header byte k+5 is sampled.
- tlast appears 1 cycle after the first cycle with rx_dv=0.
- hdr_valid appears 1 cycle after the high nibble of byte 13. It is always ≥1 cycle before the first tvalid.
- tvalid beats are at least 2 cycles apart.
- A minimum inter-frame gap of 1 idle cycle must be supported; the tlast beat and the next frame's PREAMBLE may overlap.

## Configuration
- RX_ETH_CRC_EN defined:
  - A CRC-32 checker (reflected, polynomial 0xEDB88320, init 0xFFFF_FFFF) runs over all post-SFD bytes including FCS.
  - The frame passes iff the final register equals 0xDEBB20E3; failure sets tuser on tlast.
- RX_ETH_CRC_EN undefined:
  - No checker. FCS is still stripped, and tuser reflects only rx_er, dribble and runt.

## Structure
- Shared package eth_pkg:
  - state enum;
  - ETH_HDR_LEN=14 and ETH_FCS_LEN=4;
  - BCAST_MAC;
  - CRC32_POLY and CRC32_RESIDUE;
  - preamble nibble 0x5 and SFD nibble 0xD.
- One sub-module, crc32_d8: byte-wide combinational next-CRC function plus its register, instantiated only under RX_ETH_CRC_EN.

## Test plan
- Valid 64-byte frame: dst=local_mac=02:00:00:00:00:01, type 0x0800, 46 payload bytes 0x00..0x2D, correct FCS.
  - Response: hdr_valid, eth_type=0x0800, 46 beats 0x00..0x2D, tlast on 0x2D, tuser=0.
- Same frame with dst 00:11:22:33:44:55.
  - Response: no hdr_valid, no tvalid, no rx_err.
- Broadcast frame with one FCS bit flipped.
  - Response with RX_ETH_CRC_EN: 46 beats and tuser=1 on tlast.
  - Response without RX_ETH_CRC_EN: tuser=0.
- rx_er pulsed mid-payload.
  - Response: tuser=1. Alternatively, a 40-byte frame gives a runt, tuser=1 on the tlast of its 22nd payload byte.
- rx_dv dropped after 10 header bytes, or after 3 post-header bytes.
  - Response: rx_err pulse once, no tvalid.
- Two back-to-back valid frames with 1-cycle gap.
  - Response: both frames delivered intact, headers latched per frame.
- Reset asserted mid-payload.
  - Response: outputs 0 immediately, no tlast, next frame received correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive path.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned CNT_W       = 11;
  localparam int unsigned ETH_HDR_LEN = 14;
  localparam int unsigned ETH_FCS_LEN = 4;

  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;

endpackage

// File: rtl/rx_eth_if.sv
// Byte-wide AXI-stream payload bus (no tready: the sink always accepts).
interface rx_eth_if;
  import eth_pkg::*;

  logic [BYTE_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/crc32_d8.sv
// Reflected CRC-32 register advanced one byte per enabled cycle; no final inversion.
module crc32_d8
  import eth_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic [31:0]       crc
);

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [BYTE_W-1:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= '1;
    else if (init) crc <= '1;
    else if (en)   crc <= crc_next(crc, data);
  end

endmodule

// File: rtl/rx_eth.sv
// MII receive: preamble/SFD strip, header parse + MAC filter, FCS strip to AXI-stream.
// Define RX_ETH_CRC_EN to add the CRC-32 check feeding tuser.
module rx_eth
  import eth_pkg::*;
#(
  parameter int unsigned MIN_FRAME = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [47:0] local_mac,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] eth_type,
  output logic        hdr_valid,
  output logic        rx_err,
  rx_eth_if.master    m_axis
);

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(ETH_HDR_LEN - 1);
  localparam logic [CNT_W-1:0] PAY_FULL = CNT_W'(ETH_HDR_LEN + ETH_FCS_LEN + 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME);
  localparam logic [CNT_W-1:0] SRC_POS  = CNT_W'(6);
  localparam logic [CNT_W-1:0] TYPE_POS = CNT_W'(12);

  state_t state, state_nx;

  logic                         dv_q, phase, saw5, er_seen;
  logic [3:0]                   lo_nib;
  logic [CNT_W-1:0]             cnt;
  logic [4:0][BYTE_W-1:0]       dl;
  logic [47:0]                  sh_dst, sh_src;
  logic [BYTE_W-1:0]            sh_type_hi;

  logic [BYTE_W-1:0]            tdata, tdata_nx;
  logic                         tvalid, tvalid_nx, tlast, tlast_nx, tuser, tuser_nx;
  logic                         hdr_valid_nx, rx_err_nx;

  logic [BYTE_W-1:0]            byte_c;
  logic                         byte_done_c, sfd_c, crc_bad_c, frame_err_c;

  assign byte_c      = {rxd, lo_nib};
  assign byte_done_c = rx_dv && phase && (state == ST_HEADER || state == ST_PAYLOAD);
  assign sfd_c       = (state == ST_PREAMBLE) && rx_dv && (rxd == SFD_NIB) && saw5;

`ifdef RX_ETH_CRC_EN
  logic [31:0] crc;
  crc32_d8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (state == ST_PREAMBLE),
    .en    (byte_done_c),
    .data  (byte_c),
    .crc   (crc)
  );
  assign crc_bad_c = (crc != CRC32_RESIDUE);
`else
  assign crc_bad_c = 1'b0;
`endif

  // phase still reflects the last live nibble on the rx_dv-low cycle: 1 means dribble
  assign frame_err_c = er_seen | phase | (cnt < MIN_CNT) | crc_bad_c;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hdr_valid <= 1'b0;
      rx_err    <= 1'b0;
      tdata     <= '0;
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      tuser     <= 1'b0;
    end else begin
      state     <= state_nx;
      hdr_valid <= hdr_valid_nx;
      rx_err    <= rx_err_nx;
      tdata     <= tdata_nx;
      tvalid    <= tvalid_nx;
      tlast     <= tlast_nx;
      tuser     <= tuser_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    hdr_valid_nx = 1'b0;
    rx_err_nx    = 1'b0;
    tdata_nx     = tdata;
    tvalid_nx    = 1'b0;
    tlast_nx     = 1'b0;
    tuser_nx     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_dv && !dv_q) state_nx = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (!rx_dv)                state_nx = ST_IDLE;
        else if (sfd_c)            state_nx = ST_HEADER;
        else if (rxd != PRE_NIB)   state_nx = ST_DROP;
      end
      ST_HEADER: begin
        if (!rx_dv) begin
          state_nx  = ST_IDLE;
          rx_err_nx = 1'b1;
        end else if (byte_done_c && cnt == HDR_LAST) begin
          if (sh_dst == local_mac || sh_dst == BCAST_MAC) begin
            state_nx     = ST_PAYLOAD;
            hdr_valid_nx = 1'b1;
          end else begin
            state_nx = ST_DROP;
          end
        end
      end
      ST_PAYLOAD: begin
        // The 5-byte line holds the last payload byte plus the 4 FCS bytes at rx_dv fall
        if (!rx_dv) begin
          state_nx = ST_IDLE;
          if (cnt >= PAY_FULL) begin
            tvalid_nx = 1'b1;
            tlast_nx  = 1'b1;
            tuser_nx  = frame_err_c;
            tdata_nx  = dl[4];
          end else begin
            rx_err_nx = 1'b1;
          end
        end else if (byte_done_c && cnt >= PAY_FULL) begin
          tvalid_nx = 1'b1;
          tdata_nx  = dl[4];
        end
      end
      ST_DROP: begin
        if (!rx_dv) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Nibble assembly, byte counting, header shadows and payload delay line.
  // dv_q resets high so a frame already running at reset release is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q       <= 1'b1;
      phase      <= 1'b0;
      saw5       <= 1'b0;
      er_seen    <= 1'b0;
      lo_nib     <= '0;
      cnt        <= '0;
      dl         <= '0;
      sh_dst     <= '0;
      sh_src     <= '0;
      sh_type_hi <= '0;
      dst_mac    <= '0;
      src_mac    <= '0;
      eth_type   <= '0;
    end else begin
      dv_q <= rx_dv;

      if (!rx_dv || sfd_c) phase <= 1'b0;
      else                 phase <= ~phase;
      if (rx_dv && !phase) lo_nib <= rxd;

      if (state == ST_IDLE)                                     saw5 <= rx_dv && (rxd == PRE_NIB);
      else if (state == ST_PREAMBLE && rx_dv && rxd == PRE_NIB) saw5 <= 1'b1;

      if (state == ST_IDLE) er_seen <= rx_dv & rx_er;
      else                  er_seen <= er_seen | (rx_dv & rx_er);

      if (sfd_c)                         cnt <= '0;
      else if (byte_done_c && cnt != '1) cnt <= cnt + CNT_W'(1);

      if (byte_done_c && state == ST_HEADER) begin
        if (cnt < SRC_POS)        sh_dst     <= {sh_dst[39:0], byte_c};
        else if (cnt < TYPE_POS)  sh_src     <= {sh_src[39:0], byte_c};
        else if (cnt == TYPE_POS) sh_type_hi <= byte_c;
      end

      if (byte_done_c && state == ST_PAYLOAD) dl <= {dl[3:0], byte_c};

      if (hdr_valid_nx) begin
        dst_mac  <= sh_dst;
        src_mac  <= sh_src;
        eth_type <= {sh_type_hi, byte_c};
      end
    end
  end

  assign m_axis.tdata  = tdata;
  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = tlast;
  assign m_axis.tuser  = tuser;

endmodule

// File: tb/tb_rx_eth.sv
// Scoreboard bench for rx_eth: frame-level expectations queued at drive time, popped by a monitor.
module tb_rx_eth;

  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_A = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [47:0] SRC_B = 48'h02_12_34_56_78_9A;
`ifdef RX_ETH_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rxd;
  logic        rx_dv;
  logic        rx_er;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] eth_type;
  logic        hdr_valid, rx_err;

  rx_eth_if axis ();

  rx_eth #(.MIN_FRAME(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .local_mac (LOCAL),
    .dst_mac   (dst_mac),
    .src_mac   (src_mac),
    .eth_type  (eth_type),
    .hdr_valid (hdr_valid),
    .rx_err    (rx_err),
    .m_axis    (axis)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int err_exp  = 0;
  int err_seen = 0;
  bit mon_en = 1'b1;
  logic [9:0]   beat_q [$];
  logic [111:0] hdr_q  [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                             input int plen, input logic [7:0] pstart, output bq_t f);
    logic [31:0] c;
    f = {};
    for (int i = 5; i >= 0; i--) f.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) f.push_back(src[i*8 +: 8]);
    f.push_back(typ[15:8]);
    f.push_back(typ[7:0]);
    for (int i = 0; i < plen; i++) f.push_back(pstart + 8'(i));
    c = '1;
    foreach (f[i]) c = crc_upd(c, f[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) f.push_back(c[i*8 +: 8]);
  endtask

  task automatic expect_frame(input bq_t f, input int len, input bit er, input bit drib, input bit corrupt);
    logic [47:0] d, s;
    logic [15:0] t;
    logic        u;
    if (len < 14) begin
      err_exp++;
      return;
    end
    d = '0;
    s = '0;
    for (int i = 0; i < 6; i++) begin
      d = {d[39:0], f[i]};
      s = {s[39:0], f[6+i]};
    end
    t = {f[12], f[13]};
    if (d != LOCAL && d != BCAST) return;
    hdr_q.push_back({d, s, t});
    if (len - 14 < 5) begin
      err_exp++;
      return;
    end
    u = er | drib | (len < 64) | (CRC_EN & corrupt);
    for (int k = 14; k <= len - 5; k++) beat_q.push_back({k == len - 5, (k == len - 5) & u, f[k]});
  endtask

  task automatic drive_nib(input logic [3:0] n, input logic e);
    @(negedge clk);
    rx_dv = 1'b1;
    rxd   = n;
    rx_er = e;
  endtask

  task automatic send_pre();
    for (int i = 0; i < 15; i++) drive_nib(4'h5, 1'b0);
    drive_nib(4'hD, 1'b0);
  endtask

  task automatic send_bytes(input bq_t f, input int from, input int to, input int er_at);
    for (int b = from; b < to; b++) begin
      drive_nib(f[b][3:0], b == er_at);
      drive_nib(f[b][7:4], 1'b0);
    end
  endtask

  task automatic send_end(input bit dribble, input int gap);
    if (dribble) drive_nib(4'hA, 1'b0);
    @(negedge clk);
    rx_dv = 1'b0;
    rxd   = 4'h0;
    rx_er = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic run_frame(input bq_t f, input int len, input int er_at, input bit dribble,
                           input bit corrupt, input int gap);
    bq_t g;
    g = f;
    if (corrupt) g[g.size()-1] = g[g.size()-1] ^ 8'h01;
    expect_frame(g, len, (er_at >= 0 && er_at < len), dribble, corrupt);
    send_pre();
    send_bytes(g, 0, len, er_at);
    send_end(dribble, gap);
  endtask

  // Monitor: every output event must match the head of its expectation queue
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (axis.tvalid) begin
        check("beat_avail", 64'(beat_q.size() > 0), 64'd1);
        if (beat_q.size() > 0)
          check("beat", 64'({axis.tlast, axis.tlast & axis.tuser, axis.tdata}), 64'(beat_q.pop_front()));
      end
      if (hdr_valid) begin
        check("hdr_avail", 64'(hdr_q.size() > 0), 64'd1);
        if (hdr_q.size() > 0) begin
          logic [111:0] h;
          h = hdr_q.pop_front();
          check("hdr_dst", 64'(dst_mac), 64'(h[111:64]));
          check("hdr_src", 64'(src_mac), 64'(h[63:16]));
          check("hdr_type", 64'(eth_type), 64'(h[15:0]));
        end
      end
      if (rx_err) begin
        check("rx_err_avail", 64'(err_seen < err_exp), 64'd1);
        err_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    bq_t f;
    rst_n = 1'b0;
    rx_dv = 1'b0;
    rxd   = 4'h0;
    rx_er = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dst",    64'(dst_mac), 64'd0);
    check("rst_src",    64'(src_mac), 64'd0);
    check("rst_type",   64'(eth_type), 64'd0);
    check("rst_hdrv",   64'(hdr_valid), 64'd0);
    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_tdata",  64'(axis.tdata), 64'd0);
    check("rst_rx_err", 64'(rx_err), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Valid 64-byte frame to the station address
    build_frame(LOCAL, SRC_A, 16'h0800, 46, 8'h00, f);
    run_frame(f, 64, -1, 1'b0, 1'b0, 12);
    // Filtered destination
    build_frame(48'h00_11_22_33_44_55, SRC_A, 16'h0800, 46, 8'h00, f);
    run_frame(f, 64, -1, 1'b0, 1'b0, 12);
    // Broadcast with a corrupted FCS bit
    build_frame(BCAST, SRC_B, 16'h0806, 46, 8'h30, f);
    run_frame(f, 64, -1, 1'b0, 1'b1, 12);
    // rx_er mid-payload
    build_frame(LOCAL, SRC_A, 16'h0800, 46, 8'h60, f);
    run_frame(f, 64, 30, 1'b0, 1'b0, 12);
    // 40-byte runt
    build_frame(LOCAL, SRC_A, 16'h0800, 22, 8'h90, f);
    run_frame(f, 40, -1, 1'b0, 1'b0, 12);
    // Dribble nibble after a good frame
    build_frame(LOCAL, SRC_B, 16'h88B5, 50, 8'hC0, f);
    run_frame(f, 68, -1, 1'b1, 1'b0, 12);
    // Truncated after 10 header bytes, and after 3 post-header bytes
    build_frame(LOCAL, SRC_A, 16'h0800, 46, 8'h00, f);
    run_frame(f, 10, -1, 1'b0, 1'b0, 12);
    run_frame(f, 17, -1, 1'b0, 1'b0, 12);
    // Boundaries: 4 post-header bytes (error) and 5 (one tlast beat)
    build_frame(LOCAL, SRC_A, 16'h1234, 0, 8'h00, f);
    run_frame(f, 18, -1, 1'b0, 1'b0, 12);
    build_frame(LOCAL, SRC_B, 16'h4321, 1, 8'h5A, f);
    run_frame(f, 19, -1, 1'b0, 1'b0, 12);
    // Preamble aborted before SFD, and a bad preamble nibble
    for (int i = 0; i < 8; i++) drive_nib(4'h5, 1'b0);
    send_end(1'b0, 4);
    build_frame(LOCAL, SRC_A, 16'h0800, 46, 8'h00, f);
    for (int i = 0; i < 6; i++) drive_nib(4'h5, 1'b0);
    drive_nib(4'h7, 1'b0);
    send_bytes(f, 0, 64, -1);
    send_end(1'b0, 4);
    // Back-to-back frames with a single idle cycle
    build_frame(LOCAL, SRC_A, 16'h0800, 46, 8'h10, f);
    run_frame(f, 64, -1, 1'b0, 1'b0, 1);
    build_frame(BCAST, SRC_B, 16'h0806, 50, 8'h40, f);
    run_frame(f, 68, -1, 1'b0, 1'b0, 12);

    // Reset mid-payload; remainder of that frame must be ignored
    build_frame(LOCAL, SRC_B, 16'h86DD, 46, 8'h80, f);
    mon_en = 1'b0;
    send_pre();
    send_bytes(f, 0, 24, -1);
    check("pre_rst_type", 64'(eth_type), 64'h86DD);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("mid_rst_tdata",  64'(axis.tdata), 64'd0);
    check("mid_rst_hdrv",   64'(hdr_valid), 64'd0);
    check("mid_rst_dst",    64'(dst_mac), 64'd0);
    check("mid_rst_type",   64'(eth_type), 64'd0);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_bytes(f, 24, 64, -1);
    send_end(1'b0, 4);
    check("post_rst_dst", 64'(dst_mac), 64'd0);
    build_frame(LOCAL, SRC_A, 16'h0800, 46, 8'hA0, f);
    run_frame(f, 64, -1, 1'b0, 1'b0, 12);

    repeat (20) @(negedge clk);
    check("beats_left", 64'(beat_q.size()), 64'd0);
    check("hdrs_left",  64'(hdr_q.size()), 64'd0);
    check("rx_err_cnt", 64'(err_seen), 64'(err_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
